// File: rtl/phaser_out_tap_ctrl.sv
// Tap sequencer for one X_PHASER_OUT: walks fine then coarse taps one pulse at a time
// toward an absolute target, with settle gap, overflow abort and counter read-back.
module phaser_out_tap_ctrl #(
  parameter int FINE_INIT   = 0,
  parameter int COARSE_INIT = 0,
  parameter int PULSE_GAP   = 8,
  parameter int READ_LAT    = 2
) (
  input  logic       SYSCLK,
  input  logic       RST,
  input  logic       REQVALID,
  output logic       REQREADY,
  input  logic [5:0] REQFINE,
  input  logic [5:0] REQCOARSE,
  input  logic       RDREQ,
  output logic       DONE,
  output logic       ERR,
  output logic [5:0] CURFINE,
  output logic [5:0] CURCOARSE,
  output logic [8:0] RDVAL,
  output logic       FINEENABLE,
  output logic       FINEINC,
  output logic       COARSEENABLE,
  output logic       COARSEINC,
  output logic       COUNTERREADEN,
  input  logic       FINEOVERFLOW,
  input  logic       COARSEOVERFLOW,
  input  logic [8:0] COUNTERREADVAL
);

  typedef enum logic [2:0] {
    S_IDLE, S_FSTEP, S_FWAIT, S_CSTEP, S_CWAIT, S_RDPULSE, S_RDWAIT
  } state_t;

  localparam logic [5:0] FINE_RST   = 6'(FINE_INIT);
  localparam logic [5:0] COARSE_RST = 6'(COARSE_INIT);
  // A step cycle plus GAP_CNT+1 wait cycles gives PULSE_GAP cycles between pulses.
  localparam logic [7:0] GAP_CNT    = (PULSE_GAP > 1) ? 8'(PULSE_GAP - 2) : 8'd0;
  localparam logic [7:0] RD_CNT     = 8'(READ_LAT);

  function automatic logic [5:0] tap_step(input logic [5:0] cur, input logic up);
    if (up) return (cur == 6'd63) ? cur : cur + 6'd1;
    else    return (cur == 6'd0)  ? cur : cur - 6'd1;
  endfunction

  function automatic state_t next_after(input logic fine_left, input logic coarse_left);
    if (fine_left)        return S_FSTEP;
    else if (coarse_left) return S_CSTEP;
    else                  return S_IDLE;
  endfunction

  state_t     r_state;
  logic       r_ready, r_done, r_err, r_zpend;
  logic [5:0] r_cur_fine, r_cur_coarse, r_tgt_fine, r_tgt_coarse;
  logic [8:0] r_rdval;
  logic       r_fen, r_finc, r_cen, r_cinc, r_rden;
  logic [7:0] r_cnt;

  logic       w_fine_up, w_coarse_up, w_ovf;
  logic [5:0] w_fine_stepped, w_coarse_stepped;
  state_t     w_fstep_next, w_cstep_next, w_wait_next;

  assign w_fine_up        = (r_tgt_fine > r_cur_fine);
  assign w_coarse_up      = (r_tgt_coarse > r_cur_coarse);
  assign w_fine_stepped   = tap_step(r_cur_fine, w_fine_up);
  assign w_coarse_stepped = tap_step(r_cur_coarse, w_coarse_up);
  assign w_ovf            = FINEOVERFLOW | COARSEOVERFLOW;
  // Successor states; the step variants only matter when there is no wait state.
  assign w_fstep_next = next_after(w_fine_stepped != r_tgt_fine, r_cur_coarse != r_tgt_coarse);
  assign w_cstep_next = next_after(1'b0, w_coarse_stepped != r_tgt_coarse);
  assign w_wait_next  = next_after(r_cur_fine != r_tgt_fine, r_cur_coarse != r_tgt_coarse);

  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_zpend      <= 1'b0;
      r_cur_fine   <= FINE_RST;
      r_cur_coarse <= COARSE_RST;
      r_tgt_fine   <= FINE_RST;
      r_tgt_coarse <= COARSE_RST;
      r_rdval      <= 9'd0;
      r_fen        <= 1'b0;
      r_finc       <= 1'b0;
      r_cen        <= 1'b0;
      r_cinc       <= 1'b0;
      r_rden       <= 1'b0;
      r_cnt        <= 8'd0;
    end else begin
      r_done <= 1'b0;
      r_fen  <= 1'b0;
      r_cen  <= 1'b0;
      r_rden <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_zpend) begin
            r_zpend <= 1'b0;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
          end else if (REQVALID && r_ready) begin
            r_tgt_fine   <= REQFINE;
            r_tgt_coarse <= REQCOARSE;
            r_err        <= 1'b0;
            r_ready      <= 1'b0;
            if (REQFINE != r_cur_fine)          r_state <= S_FSTEP;
            else if (REQCOARSE != r_cur_coarse) r_state <= S_CSTEP;
            else                                r_zpend <= 1'b1;
          end else if (RDREQ && r_ready) begin
            r_ready <= 1'b0;
            r_state <= S_RDPULSE;
          end
        end
        S_FSTEP, S_CSTEP: begin
          if (w_ovf) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            if (r_state == S_FSTEP) begin
              r_fen      <= 1'b1;
              r_finc     <= w_fine_up;
              r_cur_fine <= w_fine_stepped;
            end else begin
              r_cen        <= 1'b1;
              r_cinc       <= w_coarse_up;
              r_cur_coarse <= w_coarse_stepped;
            end
            if (PULSE_GAP == 1) begin
              r_state <= (r_state == S_FSTEP) ? w_fstep_next : w_cstep_next;
              if (((r_state == S_FSTEP) ? w_fstep_next : w_cstep_next) == S_IDLE) begin
                r_done  <= 1'b1;
                r_ready <= 1'b1;
              end
            end else begin
              r_cnt   <= GAP_CNT;
              r_state <= (r_state == S_FSTEP) ? S_FWAIT : S_CWAIT;
            end
          end
        end
        S_FWAIT, S_CWAIT: begin
          if (w_ovf) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            r_state <= w_wait_next;
            if (w_wait_next == S_IDLE) begin
              r_done  <= 1'b1;
              r_ready <= 1'b1;
            end
          end
        end
        S_RDPULSE: begin
          r_rden  <= 1'b1;
          r_cnt   <= RD_CNT;
          r_state <= S_RDWAIT;
        end
        S_RDWAIT: begin
          // Sample READ_LAT cycles after the cycle COUNTERREADEN is high.
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            r_rdval <= COUNTERREADVAL;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign REQREADY      = r_ready;
  assign DONE          = r_done;
  assign ERR           = r_err;
  assign CURFINE       = r_cur_fine;
  assign CURCOARSE     = r_cur_coarse;
  assign RDVAL         = r_rdval;
  assign FINEENABLE    = r_fen;
  assign FINEINC       = r_finc;
  assign COARSEENABLE  = r_cen;
  assign COARSEINC     = r_cinc;
  assign COUNTERREADEN = r_rden;

endmodule
